mem_block_arbiter: RTL

Parametrised block-granular backing memory with an N-channel round-robin front end. It replaces the single-port, fixed-stall BRAM hookup under the cache hierarchy. Any number of requesters (I-cache, D-cache, later DMA) share one memory array. Each request completes after a programmable latency. Writes use a per-bit mask. Each channel gets its own done pulse.

---
 rtl/mem_block_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_block_arbiter.sv
// Block-granular backing memory shared by NUM_CH requesters through a round-robin
// arbiter; each access completes after LATENCY wait cycles with a per-channel done pulse.
module mem_block_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_WIDTH   = 512,
  parameter int OFFSET_BITS   = 6,
  parameter int DEPTH_LOG     = 10,
  parameter int NUM_CH        = 2,
  parameter int LATENCY       = 100,
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CH-1:0]               ch_read_enable,
  input  logic [NUM_CH-1:0]               ch_write_enable,
  input  logic [NUM_CH*ADDRESS_WIDTH-1:0] ch_address,
  input  logic [NUM_CH*BLOCK_WIDTH-1:0]   ch_data_give,
  input  logic [NUM_CH*BLOCK_WIDTH-1:0]   ch_data_mask,
  output logic [BLOCK_WIDTH-1:0]          data_get,
  output logic [NUM_CH-1:0]               ch_read_done,
  output logic [NUM_CH-1:0]               ch_write_done,
  output logic [GW-1:0]                   grant_id,
  output logic                            busy
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                   state, state_next;
  logic                     grant, access, finish;
  logic [CW-1:0]            count;
  logic [GW-1:0]            rr_ptr, rr_next, pick, cand_id;
  logic [GW:0]              cand;
  logic                     found;
  logic [NUM_CH-1:0]        eligible, grant_onehot;

  logic [DEPTH_LOG-1:0]     sel_idx, lat_idx;
  logic [BLOCK_WIDTH-1:0]   sel_data, sel_mask, lat_data, lat_mask;
  logic                     sel_write, lat_write;

  logic [BLOCK_WIDTH-1:0]   mem [0:(1<<DEPTH_LOG)-1];

  // A channel that just saw its done pulse sits out one arbitration so it is not regranted.
  assign eligible = (ch_read_enable | ch_write_enable) & ~(ch_read_done | ch_write_done);

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  // NOTE: combinational blocks use blocking '=' so later statements see earlier results;
  // clocked blocks use '<=' so every register samples pre-edge values.
  always_comb begin
    pick    = rr_ptr;
    found   = 1'b0;
    cand    = '0;
    cand_id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (GW+1)'(i);
      if (cand >= (GW+1)'(NUM_CH)) cand = cand - (GW+1)'(NUM_CH);
      cand_id = cand[GW-1:0];
      if (eligible[cand_id]) begin
        pick  = cand_id;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_idx   = '0;
    sel_data  = '0;
    sel_mask  = '0;
    sel_write = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pick == GW'(c)) begin
        sel_idx   = ch_address[c*ADDRESS_WIDTH + OFFSET_BITS +: DEPTH_LOG];
        sel_data  = ch_data_give[c*BLOCK_WIDTH +: BLOCK_WIDTH];
        sel_mask  = ch_data_mask[c*BLOCK_WIDTH +: BLOCK_WIDTH];
        sel_write = ch_write_enable[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    access     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (found) begin
        state_next = WAIT;
        grant      = 1'b1;
      end
      WAIT: if (count == '0) begin
        state_next = DONE;
        access     = 1'b1;
      end
      DONE: begin
        state_next = IDLE;
        finish     = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy         = (state != IDLE);
  assign rr_next      = (grant_id == GW'(NUM_CH - 1)) ? '0 : grant_id + GW'(1);
  assign grant_onehot = NUM_CH'(1) << grant_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      rr_ptr        <= '0;
      grant_id      <= '0;
      data_get      <= '0;
      ch_read_done  <= '0;
      ch_write_done <= '0;
    end else begin
      ch_read_done  <= '0;
      ch_write_done <= '0;
      if (grant) begin
        grant_id <= pick;
        count    <= CW'(LATENCY - 1);
      end else if (state == WAIT && count != '0) begin
        count <= count - CW'(1);
      end
      if (access && !lat_write) data_get <= mem[lat_idx];
      if (finish) begin
        rr_ptr <= rr_next;
        if (lat_write) ch_write_done <= grant_onehot;
        else           ch_read_done  <= grant_onehot;
      end
    end
  end

  // NOTE: request latches and the array carry no reset; they are only consumed after a
  // grant or a write, and leaving the array unreset lets it map onto block RAM.
  always_ff @(posedge clk) begin
    if (grant) begin
      lat_write <= sel_write;
      lat_idx   <= sel_idx;
      lat_data  <= sel_data;
      lat_mask  <= sel_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && access && lat_write)
      mem[lat_idx] <= (mem[lat_idx] & ~lat_mask) | (lat_data & lat_mask);
  end

endmodule
